// File: rtl/slave_out_port_if.sv
// Handshake bundle between slave storage/control and the slave-side serial transmitter.
// The slave modport is the transmitter's view; the master modport is its environment.
interface slave_out_port_if #(
  parameter int BURST_LEN = 12,
  parameter int DATA_LEN  = 8
);
  logic                 start;
  logic [BURST_LEN-1:0] burst_num;
  logic                 data_req;
  logic                 data_ready;
  logic [DATA_LEN-1:0]  data_in;
  logic                 master_ready;
  logic                 tx_data;
  logic                 slave_valid;
  logic                 busy;
  logic                 tx_done;

  modport slave (
    input  start, burst_num, data_ready, data_in, master_ready,
    output data_req, tx_data, slave_valid, busy, tx_done
  );

  modport master (
    output start, burst_num, data_ready, data_in, master_ready,
    input  data_req, tx_data, slave_valid, busy, tx_done
  );
endinterface

// File: rtl/slave_out_port.sv
// Slave-side serial transmitter: fetches words from storage and shifts them out LSB-first,
// one word per master_ready handshake, with burst support. All outputs are registered.
module slave_out_port #(
  parameter int BURST_LEN = 12,
  parameter int DATA_LEN  = 8
) (
  input logic              clk,
  input logic              reset,
  slave_out_port_if.slave  bus
);

  localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_LEN - 1);
  localparam logic [BURST_LEN-1:0] ONE_WORD = BURST_LEN'(1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, SEND, DONE} state_t;

  state_t               state, next_state;
  logic [DATA_LEN-1:0]  shift_q;
  logic [BURST_LEN-1:0] words_left;
  logic [CNT_W-1:0]     bit_cnt;

  logic data_req_q, tx_data_q, slave_valid_q, busy_q, tx_done_q;
  logic data_req_d, tx_data_d, slave_valid_d, busy_d, tx_done_d;

  // State register; outputs are registered from their next-state values.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      data_req_q    <= 1'b0;
      tx_data_q     <= 1'b0;
      slave_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state         <= next_state;
      data_req_q    <= data_req_d;
      tx_data_q     <= tx_data_d;
      slave_valid_q <= slave_valid_d;
      busy_q        <= busy_d;
      tx_done_q     <= tx_done_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.start)        next_state = FETCH;
      FETCH:    if (bus.data_ready)   next_state = WAIT_RDY;
      WAIT_RDY: if (bus.master_ready) next_state = SEND;
      SEND:     if (bit_cnt == LAST_BIT)
                  next_state = (words_left == ONE_WORD) ? DONE : FETCH;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Only WAIT_RDY and SEND lead into SEND, and both leave the next bit at shift_q[0].
  always_comb begin
    data_req_d    = (next_state == FETCH);
    slave_valid_d = (next_state == SEND);
    tx_data_d     = (next_state == SEND) ? shift_q[0] : 1'b0;
    busy_d        = (next_state != IDLE);
    tx_done_d     = (next_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      words_left <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.start)
            words_left <= (bus.burst_num == '0) ? ONE_WORD : bus.burst_num;
        FETCH:
          if (bus.data_ready) shift_q <= bus.data_in;
        WAIT_RDY:
          if (bus.master_ready) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= '0;
          end
        SEND: begin
          shift_q <= shift_q >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            words_left <= words_left - ONE_WORD;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_req    = data_req_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.slave_valid = slave_valid_q;
  assign bus.busy        = busy_q;
  assign bus.tx_done     = tx_done_q;

endmodule

// File: tb/tb_slave_out_port.sv
// Directed bench for slave_out_port: single word, burst, backpressure, storage stall,
// mid-word reset and start-while-busy, checked against hand-computed bit streams.
module tb_slave_out_port;

  localparam int BURST_LEN = 12;
  localparam int DATA_LEN  = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cap_cnt;
  int   done_cnt;
  logic [DATA_LEN-1:0] mem [16];

  slave_out_port_if #(.BURST_LEN(BURST_LEN), .DATA_LEN(DATA_LEN)) bus_if ();

  slave_out_port #(.BURST_LEN(BURST_LEN), .DATA_LEN(DATA_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Storage model: the word served is indexed by the number of captures so far.
  assign bus_if.data_in = mem[cap_cnt[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.data_req && bus_if.data_ready) cap_cnt <= cap_cnt + 1;
    if (bus_if.tx_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int waited, input string tag);
    waited = 0;
    while (!bus_if.slave_valid && waited < max_cycles) begin
      step(1);
      waited++;
    end
    check(tag, 32'(bus_if.slave_valid), 32'd1);
  endtask

  // Checks nbits consecutive LSB-first bits; drops master_ready after bit drop_at.
  task automatic collect_word(input logic [DATA_LEN-1:0] word, input int nbits,
                              input int drop_at, input string tag);
    logic [DATA_LEN-1:0] w;
    int errs;
    w = word;
    errs = 0;
    for (int i = 0; i < nbits; i++) begin
      if (bus_if.slave_valid !== 1'b1 || bus_if.tx_data !== w[i]) errs++;
      if (i == drop_at) bus_if.master_ready = 1'b0;
      step(1);
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  task automatic pulse_start(input logic [BURST_LEN-1:0] n);
    bus_if.burst_num = n;
    bus_if.start     = 1'b1;
    step(1);
    bus_if.start     = 1'b0;
  endtask

  initial begin
    int waited, cap0, done0, errs;
    total    = 0;
    bad      = 0;
    cap_cnt  = 0;
    done_cnt = 0;
    mem[0] = 8'hB5; mem[1] = 8'h5E; mem[2] = 8'hD4; mem[3] = 8'hDE;
    mem[4] = 8'hA7; mem[5] = 8'h3C; mem[6] = 8'h96; mem[7] = 8'h4B;
    mem[8] = 8'hE1; mem[9] = 8'h0F;
    for (int i = 10; i < 16; i++) mem[i] = 8'h00;

    reset               = 1'b1;
    bus_if.start        = 1'b0;
    bus_if.burst_num    = '0;
    bus_if.data_ready   = 1'b0;
    bus_if.master_ready = 1'b0;
    step(2);
    check("reset_outputs", {27'd0, bus_if.data_req, bus_if.tx_data, bus_if.slave_valid,
                            bus_if.busy, bus_if.tx_done}, 32'd0);
    reset = 1'b0;
    step(1);

    // 1. Single word, minimum latency
    bus_if.data_ready   = 1'b1;
    bus_if.master_ready = 1'b1;
    pulse_start(12'd0);
    check("t1_fetch", {29'd0, bus_if.data_req, bus_if.busy, bus_if.slave_valid}, 32'b110);
    step(1);
    check("t1_wait", {30'd0, bus_if.data_req, bus_if.slave_valid}, 32'd0);
    step(1);
    check("t1_first_bit", {30'd0, bus_if.slave_valid, bus_if.tx_data}, 32'b11);
    collect_word(8'hB5, 8, -1, "t1_word");
    check("t1_done", {29'd0, bus_if.tx_done, bus_if.slave_valid, bus_if.busy}, 32'b101);
    step(1);
    check("t1_idle", {30'd0, bus_if.tx_done, bus_if.busy}, 32'd0);

    // 2. Three-word burst
    cap0 = cap_cnt; done0 = done_cnt;
    pulse_start(12'd3);
    wait_valid(10, waited, "t2_w0_valid");
    check("t2_w0_latency", 32'(waited), 32'd2);
    collect_word(8'h5E, 8, -1, "t2_w0");
    check("t2_gap_fetch", {30'd0, bus_if.data_req, bus_if.slave_valid}, 32'b10);
    wait_valid(10, waited, "t2_w1_valid");
    check("t2_gap1", 32'(waited), 32'd2);
    collect_word(8'hD4, 8, -1, "t2_w1");
    check("t2_no_early_done", 32'(bus_if.tx_done), 32'd0);
    wait_valid(10, waited, "t2_w2_valid");
    check("t2_gap2", 32'(waited), 32'd2);
    collect_word(8'hDE, 8, -1, "t2_w2");
    check("t2_done", 32'(bus_if.tx_done), 32'd1);
    step(1);
    check("t2_captures", 32'(cap_cnt - cap0), 32'd3);
    check("t2_done_pulses", 32'(done_cnt - done0), 32'd1);
    check("t2_idle", 32'(bus_if.busy), 32'd0);

    // 3. Backpressure before the word, master_ready dropped mid-word
    bus_if.master_ready = 1'b0;
    pulse_start(12'd0);
    step(1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.slave_valid !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.data_req !== 1'b0) errs++;
      step(1);
    end
    check("t3_held", 32'(errs), 32'd0);
    bus_if.master_ready = 1'b1;
    step(1);
    check("t3_first_bit", {30'd0, bus_if.slave_valid, bus_if.tx_data}, 32'b11);
    collect_word(8'hA7, 8, 2, "t3_word_drop");
    check("t3_done", 32'(bus_if.tx_done), 32'd1);
    bus_if.master_ready = 1'b1;
    step(1);

    // 4. Storage stall: data_ready low for 5 cycles
    bus_if.data_ready = 1'b0;
    pulse_start(12'd0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.data_req !== 1'b1 || bus_if.slave_valid !== 1'b0) errs++;
      step(1);
    end
    check("t4_stall", 32'(errs), 32'd0);
    check("t4_req_6th", 32'(bus_if.data_req), 32'd1);
    bus_if.data_ready = 1'b1;
    step(1);
    check("t4_captured", {30'd0, bus_if.data_req, bus_if.slave_valid}, 32'd0);
    step(1);
    collect_word(8'h3C, 8, -1, "t4_word");
    check("t4_done", 32'(bus_if.tx_done), 32'd1);
    step(1);

    // 5. Reset after bit 3 of word 1 of a 3-word burst
    pulse_start(12'd3);
    wait_valid(10, waited, "t5_valid");
    collect_word(8'h96, 4, -1, "t5_partial");
    #2 reset = 1'b1;
    #1;
    check("t5_async_reset", {28'd0, bus_if.data_req, bus_if.tx_data, bus_if.slave_valid,
                             bus_if.busy}, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    cap0 = cap_cnt; done0 = done_cnt;
    pulse_start(12'd0);
    wait_valid(10, waited, "t5_new_valid");
    collect_word(8'h4B, 8, -1, "t5_new_word");
    check("t5_done", 32'(bus_if.tx_done), 32'd1);
    step(1);
    check("t5_one_word", 32'(cap_cnt - cap0), 32'd1);

    // 6. Start while busy is ignored; a start after tx_done is accepted
    cap0 = cap_cnt; done0 = done_cnt;
    pulse_start(12'd0);
    pulse_start(12'd5);
    wait_valid(10, waited, "t6_valid");
    collect_word(8'hE1, 8, -1, "t6_word");
    check("t6_done", 32'(bus_if.tx_done), 32'd1);
    step(1);
    check("t6_idle", 32'(bus_if.busy), 32'd0);
    step(5);
    check("t6_no_extra", {29'd0, bus_if.busy, bus_if.data_req, bus_if.slave_valid}, 32'd0);
    check("t6_captures", 32'(cap_cnt - cap0), 32'd1);
    check("t6_done_pulses", 32'(done_cnt - done0), 32'd1);
    pulse_start(12'd0);
    check("t6_restart", {30'd0, bus_if.busy, bus_if.data_req}, 32'b11);
    wait_valid(10, waited, "t6_re_valid");
    collect_word(8'h0F, 8, -1, "t6_re_word");
    check("t6_re_done", 32'(bus_if.tx_done), 32'd1);
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slave_out_port.md
Name: slave_out_port

Overview:
Slave-side serial transmitter that feeds read data to master_in_port over the 1-bit data line. On a read request it fetches words from the slave's storage interface one at a time and shifts each out LSB-first with slave_valid high. Each word starts only after master_ready is seen, and burst reads are supported. It sits in the slave, directly upstream of master_in_port's rx_data/slave_valid/master_ready inputs.

Parameters:
BURST_LEN, 12, width of burst_num and the internal word counter
DATA_LEN, 8, bits per data word

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  read request, sampled only in IDLE
burst_num  input  BURST_LEN  word count; 0 means single word, N>0 means N words; latched on start
data_req  output  1  request next word from slave storage
data_ready  input  1  storage word valid on data_in (ack of data_req)
data_in  input  DATA_LEN  word from slave storage
master_ready  input  1  master can accept a word
tx_data  output  1  serial data to master (rx_data)
slave_valid  output  1  tx_data carries a valid bit
busy  output  1  high in any state except IDLE
tx_done  output  1  one-cycle pulse after last bit of last word

Behaviour:
- All outputs registered. Reset (async, any time, including mid-word) forces IDLE; data_req, tx_data, slave_valid, busy and tx_done go to 0; the shift register, word counter and bit counter clear. No partial word resumes after reset.
- States: IDLE, FETCH, WAIT_RDY, SEND, DONE.
- IDLE:
  - start=1 at an edge loads words_left = (burst_num==0) ? 1 : burst_num and moves to FETCH.
  - burst_num is not re-sampled afterwards.
- FETCH:
  - data_req=1.
  - data_ready=1 at an edge captures data_in into the shift register, drops data_req and moves to WAIT_RDY.
  - data_req stays high indefinitely while data_ready=0.
- WAIT_RDY:
  - slave_valid=0.
  - master_ready=1 at an edge moves to SEND. At that edge tx_data takes bit 0 and slave_valid goes to 1.
- SEND:
  - Exactly DATA_LEN consecutive cycles with slave_valid=1. Bit i appears in cycle i (LSB first).
  - master_ready is checked only at word start; deassertion mid-word is ignored and the word completes.
  - After the last bit, words_left decrements (BURST_LEN-bit, no wrap; it never underflows because the exit condition is words_left==1).
  - If more words remain, go to FETCH with slave_valid=0 the next cycle. Otherwise go to DONE.
- DONE: tx_done=1 for exactly one cycle, slave_valid=0, then IDLE. busy falls on entry to IDLE.
- start is ignored while busy=1.
- Minimum latency, with data_ready and master_ready both held high: start edge E0; data_req high after E0; capture at E1; first bit (slave_valid=1) after E2; last bit ends at E2+DATA_LEN; tx_done high for one cycle after that edge.
- Burst gap: at least 2 idle cycles (slave_valid=0) between words, one each for FETCH and WAIT_RDY.
- Simultaneous events: data_ready asserted when data_req=0 is ignored. start and reset together: reset wins.

Test Plan:
1. Single word: burst_num=0, start pulse, data_in=8'hB5, data_ready and master_ready high -> tx_data 1,0,1,0,1,1,0,1 over 8 slave_valid cycles, starting 2 cycles after the start edge; tx_done one cycle later; busy back to 0.
2. Burst: burst_num=3, words 8'h5E, 8'hD4, 8'hDE -> three 8-bit LSB-first groups, each with slave_valid=1 for 8 cycles and gaps of ≥2 cycles; data_req asserted 3 times; exactly one tx_done pulse, after the third word.
3. Backpressure:
   - master_ready=0 for 20 cycles after capture -> slave_valid stays 0, state held; first bit 1 cycle after master_ready rises.
   - Dropping master_ready mid-word -> word still completes.
4. Storage stall: data_ready low for 5 cycles -> data_req held high 6 cycles; no slave_valid until capture.
5. Reset mid-word: assert reset after bit 3 of word 1 of a 3-word burst -> slave_valid, tx_data, busy and data_req go to 0 immediately; after release, a new start with burst_num=0 sends one complete word.
6. Start while busy: pulse start with burst_num=5 during a 1-word transfer -> ignored; exactly 1 word sent; a new start after tx_done is accepted.
